// File: rtl/run_length_detector_if.sv
// run_length_detector_if: data, mode and status signals of the run-length detector.
//   master: drives in/mode/clr_evt, observes tick/out/detect/run_val/run_len/evt_cnt
//   slave : the detector itself
interface run_length_detector_if #(
  parameter int CNT_W = 8,
  parameter int EVT_W = 16
);
  logic             in;
  logic [1:0]       mode;
  logic             clr_evt;
  logic             tick;
  logic             out;
  logic             detect;
  logic             run_val;
  logic [CNT_W-1:0] run_len;
  logic [EVT_W-1:0] evt_cnt;
  modport master (output in, mode, clr_evt, input tick, out, detect, run_val, run_len, evt_cnt);
  modport slave (input in, mode, clr_evt, output tick, out, detect, run_val, run_len, evt_cnt);
endinterface

// File: rtl/run_length_detector.sv
// run_length_detector: flags runs of RUN_LEN or more equal samples taken on an internal tick.
//   clk, reset : single clock, synchronous active-high reset
//   bus.in/mode/clr_evt        : serial data, polarity mode, event-counter clear
//   bus.tick/out/detect        : sample strobe, hit level, one-clk new-hit pulse
//   bus.run_val/run_len/evt_cnt: current run value, saturating length, wrapping hit count
module run_length_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int DIV     = 125000000,
  parameter int EVT_W   = 16
) (
  input logic clk,
  input logic reset,
  run_length_detector_if.slave bus
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LEN_MAX = '1;
  typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;
  state_t           state_q, state_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             run_val_q, run_val_d, detect_q, detect_d;
  logic             tick, same, qualify, hit_new;
  assign tick      = div_cnt_q == DW'(DIV - 1);
  assign div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
  assign same      = bus.in == run_val_q;
  assign qualify   = bus.mode == 2'b10 || (bus.mode == 2'b00 && !run_val_q) || (bus.mode == 2'b01 && run_val_q);
  // A continuing run keeps run_val, so qualify already reflects the value of the run entering HIT.
  assign hit_new   = tick && state_q == RUN && same && run_len_q + CNT_W'(1) == CNT_W'(RUN_LEN);
  assign detect_d  = hit_new && qualify;
  assign evt_cnt_d = bus.clr_evt ? '0 : evt_cnt_q + EVT_W'(detect_d);
  always_comb begin
    state_d   = state_q;
    run_val_d = run_val_q;
    run_len_d = run_len_q;
    if (tick) begin
      if (state_q == IDLE || !same) begin
        state_d   = RUN;
        run_val_d = bus.in;
        run_len_d = CNT_W'(1);
      end else begin
        run_len_d = run_len_q == LEN_MAX ? run_len_q : run_len_q + CNT_W'(1);
        state_d   = hit_new ? HIT : state_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      run_val_q <= 1'b0;
      run_len_q <= '0;
      detect_q  <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      run_val_q <= run_val_d;
      run_len_q <= run_len_d;
      detect_q  <= detect_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end
  assign bus.tick    = tick;
  assign bus.out     = state_q == HIT && qualify;
  assign bus.detect  = detect_q;
  assign bus.run_val = run_val_q;
  assign bus.run_len = run_len_q;
  assign bus.evt_cnt = evt_cnt_q;
endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: directed and randomized checks of two detectors (DIV=1 and DIV=5).
module tb_run_length_detector;
  logic       clk = 1'b0, rst = 1'b0, in_v = 1'b0, clr = 1'b0;
  logic [1:0] mode = 2'b00;
  int         n_tests = 0, n_fail = 0;
  int         m_cnt[2], m_ph[2], m_evt[2];
  bit         m_val[2], m_det[2];
  logic       o_out[2], o_det[2], o_val[2], o_tick[2];
  logic [3:0] o_rl[2];
  logic [7:0] o_evt[2];

  always #5 clk = ~clk;

  run_length_detector_if #(.CNT_W(4), .EVT_W(8)) a_if ();
  run_length_detector_if #(.CNT_W(4), .EVT_W(8)) b_if ();
  assign a_if.in = in_v;
  assign a_if.mode = mode;
  assign a_if.clr_evt = clr;
  assign b_if.in = in_v;
  assign b_if.mode = mode;
  assign b_if.clr_evt = clr;
  assign o_out[0] = a_if.out;
  assign o_out[1] = b_if.out;
  assign o_det[0] = a_if.detect;
  assign o_det[1] = b_if.detect;
  assign o_val[0] = a_if.run_val;
  assign o_val[1] = b_if.run_val;
  assign o_tick[0] = a_if.tick;
  assign o_tick[1] = b_if.tick;
  assign o_rl[0] = a_if.run_len;
  assign o_rl[1] = b_if.run_len;
  assign o_evt[0] = a_if.evt_cnt;
  assign o_evt[1] = b_if.evt_cnt;

  run_length_detector #(.RUN_LEN(4), .CNT_W(4), .DIV(1), .EVT_W(8)) dut_a (.clk(clk), .reset(rst), .bus(a_if.slave));
  run_length_detector #(.RUN_LEN(4), .CNT_W(4), .DIV(5), .EVT_W(8)) dut_b (.clk(clk), .reset(rst), .bus(b_if.slave));

  function automatic bit qual(logic [1:0] m, bit v);
    return m == 2'b10 || (m == 2'b00 && !v) || (m == 2'b01 && v);
  endfunction

  // Reference: m_cnt is the true count of consecutive equal samples since reset (0 = nothing sampled yet).
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int dv = d ? 5 : 1;
      if (rst) begin
        m_ph[d] = 0; m_cnt[d] = 0; m_val[d] = 0; m_evt[d] = 0; m_det[d] = 0;
      end else begin
        bit tk = m_ph[d] == dv - 1;
        m_ph[d] = tk ? 0 : m_ph[d] + 1;
        m_det[d] = 0;
        if (tk) begin
          if (m_cnt[d] == 0 || in_v != m_val[d]) begin
            m_val[d] = in_v; m_cnt[d] = 1;
          end else m_cnt[d]++;
          if (m_cnt[d] == 4 && qual(mode, m_val[d])) m_det[d] = 1;
        end
        if (m_det[d]) m_evt[d] = (m_evt[d] + 1) % 256;
        if (clr) m_evt[d] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_v = 1'b1; mode = 2'b10;
    repeat (6) step();
    do_reset();
    n_tests += 7;
    if (a_if.out !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b want 0", a_if.out); end
    if (a_if.detect !== 1'b0) begin n_fail++; $display("FAIL reset_detect: got %b want 0", a_if.detect); end
    if (a_if.run_len !== 4'd0) begin n_fail++; $display("FAIL reset_run_len: got %0d want 0", a_if.run_len); end
    if (a_if.evt_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_evt: got %0d want 0", a_if.evt_cnt); end
    if (a_if.run_val !== 1'b0) begin n_fail++; $display("FAIL reset_run_val: got %b want 0", a_if.run_val); end
    if (a_if.tick !== 1'b1) begin n_fail++; $display("FAIL reset_tick_div1: got %b want 1", a_if.tick); end
    if (b_if.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick_div5: got %b want 0", b_if.tick); end
  endtask

  task automatic test_basic_hit();
    do_reset();
    mode = 2'b00; in_v = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) begin
        n_tests++;
        if (a_if.out !== 1'b0 || a_if.detect !== 1'b0) begin
          n_fail++; $display("FAIL basic_early: sample %0d out=%b detect=%b want 0 0", i, a_if.out, a_if.detect);
        end
      end
    end
    n_tests += 5;
    if (a_if.out !== 1'b1) begin n_fail++; $display("FAIL basic_out: got %b want 1", a_if.out); end
    if (a_if.detect !== 1'b1) begin n_fail++; $display("FAIL basic_detect: got %b want 1", a_if.detect); end
    if (a_if.run_len !== 4'd4) begin n_fail++; $display("FAIL basic_run_len: got %0d want 4", a_if.run_len); end
    if (a_if.evt_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_evt: got %0d want 1", a_if.evt_cnt); end
    if (a_if.run_val !== 1'b0) begin n_fail++; $display("FAIL basic_run_val: got %b want 0", a_if.run_val); end
    step();
    n_tests += 2;
    if (a_if.detect !== 1'b0) begin n_fail++; $display("FAIL basic_one_shot: got %b want 0", a_if.detect); end
    if (a_if.out !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got %b want 1", a_if.out); end
  endtask

  task automatic test_either();
    logic [6:0] seq = 7'b1111000;
    do_reset();
    mode = 2'b10;
    for (int i = 0; i < 7; i++) begin
      in_v = seq[i];
      step();
      if (i < 6) begin
        n_tests++;
        if (a_if.detect !== 1'b0) begin n_fail++; $display("FAIL either_early_detect: sample %0d got %b want 0", i, a_if.detect); end
      end
      if (i == 2) begin
        n_tests++;
        if (a_if.run_len !== 4'd3) begin n_fail++; $display("FAIL either_zero_peak: got %0d want 3", a_if.run_len); end
      end
    end
    n_tests += 4;
    if (a_if.detect !== 1'b1) begin n_fail++; $display("FAIL either_detect: got %b want 1", a_if.detect); end
    if (a_if.run_val !== 1'b1) begin n_fail++; $display("FAIL either_run_val: got %b want 1", a_if.run_val); end
    if (a_if.run_len !== 4'd4) begin n_fail++; $display("FAIL either_run_len: got %0d want 4", a_if.run_len); end
    if (a_if.evt_cnt !== 8'd1) begin n_fail++; $display("FAIL either_evt: got %0d want 1", a_if.evt_cnt); end
    in_v = 1'b0;
    step();
    n_tests += 2;
    if (a_if.out !== 1'b0) begin n_fail++; $display("FAIL either_drop_out: got %b want 0", a_if.out); end
    if (a_if.run_len !== 4'd1) begin n_fail++; $display("FAIL either_drop_len: got %0d want 1", a_if.run_len); end
  endtask

  task automatic test_mode_change();
    do_reset();
    mode = 2'b01; in_v = 1'b0;
    repeat (5) begin
      step();
      n_tests++;
      if (a_if.detect !== 1'b0) begin n_fail++; $display("FAIL mode_no_detect: got %b want 0", a_if.detect); end
    end
    n_tests += 3;
    if (a_if.out !== 1'b0) begin n_fail++; $display("FAIL mode_masked_out: got %b want 0", a_if.out); end
    if (a_if.evt_cnt !== 8'd0) begin n_fail++; $display("FAIL mode_masked_evt: got %0d want 0", a_if.evt_cnt); end
    if (a_if.run_len !== 4'd5) begin n_fail++; $display("FAIL mode_run_len: got %0d want 5", a_if.run_len); end
    mode = 2'b10;
    #1;
    n_tests++;
    if (a_if.out !== 1'b1) begin n_fail++; $display("FAIL mode_same_cycle_out: got %b want 1", a_if.out); end
    step();
    n_tests += 2;
    if (a_if.detect !== 1'b0) begin n_fail++; $display("FAIL mode_switch_detect: got %b want 0", a_if.detect); end
    if (a_if.evt_cnt !== 8'd0) begin n_fail++; $display("FAIL mode_switch_evt: got %0d want 0", a_if.evt_cnt); end
  endtask

  task automatic test_saturate();
    int ndet = 0;
    do_reset();
    mode = 2'b10; in_v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      ndet += int'(a_if.detect);
      if (i >= 3) begin
        n_tests++;
        if (a_if.out !== 1'b1) begin n_fail++; $display("FAIL sat_out: sample %0d got %b want 1", i, a_if.out); end
      end
    end
    n_tests += 3;
    if (ndet != 1) begin n_fail++; $display("FAIL sat_detects: got %0d want 1", ndet); end
    if (a_if.run_len !== 4'd15) begin n_fail++; $display("FAIL sat_run_len: got %0d want 15", a_if.run_len); end
    if (a_if.evt_cnt !== 8'd1) begin n_fail++; $display("FAIL sat_evt: got %0d want 1", a_if.evt_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 2'b10; in_v = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      n_tests++;
      if (a_if.detect !== 1'b0) begin n_fail++; $display("FAIL mid_no_detect: got %b want 0", a_if.detect); end
    end
    n_tests += 2;
    if (a_if.run_len !== 4'd3) begin n_fail++; $display("FAIL mid_run_len: got %0d want 3", a_if.run_len); end
    if (a_if.out !== 1'b0) begin n_fail++; $display("FAIL mid_out: got %b want 0", a_if.out); end
    step();
    n_tests += 2;
    if (a_if.detect !== 1'b1) begin n_fail++; $display("FAIL mid_detect: got %b want 1", a_if.detect); end
    if (a_if.out !== 1'b1) begin n_fail++; $display("FAIL mid_hit_out: got %b want 1", a_if.out); end
  endtask

  task automatic test_div5();
    int ticks = 0;
    do_reset();
    mode = 2'b10;
    for (int c = 0; c < 20; c++) begin
      bit exp_tick = (c % 5) == 4;
      n_tests++;
      if (b_if.tick !== exp_tick) begin n_fail++; $display("FAIL div5_tick: clk %0d got %b want %b", c, b_if.tick, exp_tick); end
      in_v = exp_tick ? 1'b1 : 1'($urandom);
      clr = exp_tick && ticks == 3;
      step();
      clr = 1'b0;
      if (exp_tick) ticks++;
      n_tests++;
      if (b_if.run_len !== 4'(ticks)) begin n_fail++; $display("FAIL div5_run_len: clk %0d got %0d want %0d", c, b_if.run_len, ticks); end
      if (exp_tick && ticks == 4) begin
        n_tests += 2;
        if (b_if.detect !== 1'b1) begin n_fail++; $display("FAIL div5_detect: got %b want 1", b_if.detect); end
        if (b_if.evt_cnt !== 8'd0) begin n_fail++; $display("FAIL div5_clr_wins: got %0d want 0", b_if.evt_cnt); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    mode = 2'b10;
    repeat (600) begin
      if ($urandom_range(3) == 0) in_v = ~in_v;
      if ($urandom_range(30) == 0) mode = 2'($urandom_range(3));
      clr = $urandom_range(40) == 0;
      rst = $urandom_range(150) == 0;
      step();
      for (int d = 0; d < 2; d++) begin
        int  e_rl  = m_cnt[d] > 15 ? 15 : m_cnt[d];
        bit  e_out = m_cnt[d] >= 4 && qual(mode, m_val[d]);
        bit  e_tk  = m_ph[d] == (d ? 4 : 0);
        n_tests += 6;
        if (o_out[d] !== e_out) begin n_fail++; $display("FAIL rand_out[%0d]: got %b want %b", d, o_out[d], e_out); end
        if (o_det[d] !== m_det[d]) begin n_fail++; $display("FAIL rand_detect[%0d]: got %b want %b", d, o_det[d], m_det[d]); end
        if (o_val[d] !== m_val[d]) begin n_fail++; $display("FAIL rand_run_val[%0d]: got %b want %b", d, o_val[d], m_val[d]); end
        if (o_rl[d] !== 4'(e_rl)) begin n_fail++; $display("FAIL rand_run_len[%0d]: got %0d want %0d", d, o_rl[d], e_rl); end
        if (o_evt[d] !== 8'(m_evt[d])) begin n_fail++; $display("FAIL rand_evt[%0d]: got %0d want %0d", d, o_evt[d], m_evt[d]); end
        if (o_tick[d] !== e_tk) begin n_fail++; $display("FAIL rand_tick[%0d]: got %b want %b", d, o_tick[d], e_tk); end
      end
    end
    rst = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_either();
    test_mode_change();
    test_saturate();
    test_reset_mid();
    test_div5();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
